// File: rtl/image_buffer_loader.sv
// Byte-stream frame loader: SYNC_BYTE starts a frame, then each pixel arrives as
// a {R,G} byte followed by a {0,B} byte and is written to a dual-port frame RAM.
module image_buffer_loader #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         NUM_PIXELS = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [14:0] pixel_addr,
    output logic [11:0] rgb_pixel,
    output logic        load_busy,
    output logic        load_done,
    output logic        frame_err
);

    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    rg_q, rg_d;
    logic          err_q, err_d;
    logic          wr_en;
    logic          accept;
    logic [11:0]   rd_q;

    logic [11:0] mem [NUM_PIXELS];

    assign rx_ready  = (state_q != DONE);
    assign load_busy = (state_q == HI) || (state_q == LO);
    assign load_done = (state_q == DONE);
    assign frame_err = err_q;
    assign rgb_pixel = rd_q;
    assign accept    = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rg_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rg_q    <= rg_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rg_d    = rg_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    err_d   = 1'b0;
                    addr_d  = '0;
                    state_d = HI;
                end
            end
            HI: begin
                if (accept) begin
                    rg_d    = rx_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    wr_en = 1'b1;
                    // A non-zero upper nibble is flagged but the pixel is still stored.
                    if (rx_data[7:4] != 4'h0) begin
                        err_d = 1'b1;
                    end
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = HI;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= {rg_q, rx_data[3:0]};
        end
    end

    // Separate read register gives read-before-write on address collisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= 12'h000;
        end else begin
            rd_q <= mem[pixel_addr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_image_buffer_loader.sv
// Scoreboard bench for image_buffer_loader using a reduced frame size.
module tb_image_buffer_loader;

    localparam int         N    = 256;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [14:0] pixel_addr = 15'd0;
    logic [11:0] rgb_pixel;
    logic        load_busy;
    logic        load_done;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] exp_mem [N];
    logic [7:0]  frame_hi [N];
    logic [7:0]  frame_lo [N];
    logic [11:0] sb_q [$];

    image_buffer_loader #(.SYNC_BYTE(SYNC), .NUM_PIXELS(N)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
        .load_busy(load_busy), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic fill_frame();
        for (int i = 0; i < N; i++) begin
            frame_hi[i] = 8'($urandom_range(255));
            frame_lo[i] = {4'h0, 4'($urandom_range(15))};
        end
    endtask

    // Presents one byte until accepted; gap_pct adds random idle cycles with garbage data.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit acc = 0;
        while ($urandom_range(99) < gap_pct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom_range(255));
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 8 && !acc; t++) begin
            acc = rx_ready;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL handshake: byte %02h not accepted, rx_ready=%0b required 1", b, rx_ready);
        end
    endtask

    task automatic readback_all(input string name);
        logic [11:0] e;
        for (int i = 0; i < N; i++) begin
            pixel_addr = 15'(i);
            sb_q.push_back(exp_mem[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (rgb_pixel !== e) begin
                n_bad++;
                $display("FAIL %s readback addr %0d: got %03h required %03h", name, i, rgb_pixel, e);
            end
        end
        $display("%s: readback of %0d pixels done", name, N);
    endtask

    task automatic load_frame(input int gap_pct, input int snoop_idx, input string name);
        bit exp_err = 0;
        logic [11:0] e;
        send_byte(SYNC, gap_pct);
        n_cmp++;
        if (load_busy !== 1'b1 || frame_err !== 1'b0 || load_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after sync: busy/err/done=%0b%0b%0b required 100", name, load_busy, frame_err, load_done);
        end
        for (int i = 0; i < N; i++) begin
            send_byte(frame_hi[i], gap_pct);
            if (i == snoop_idx) begin
                pixel_addr = 15'(i);
                sb_q.push_back(exp_mem[i]);
            end
            exp_mem[i] = {frame_hi[i], frame_lo[i][3:0]};
            if (frame_lo[i][7:4] != 4'h0) exp_err = 1'b1;
            send_byte(frame_lo[i], gap_pct);
            if (i == snoop_idx) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (rgb_pixel !== e) begin
                    n_bad++;
                    $display("FAIL %s collision old addr %0d: got %03h required %03h", name, i, rgb_pixel, e);
                end
                sb_q.push_back(exp_mem[i]);
                @(posedge clk); #1;
                e = sb_q.pop_front();
                n_cmp++;
                if (rgb_pixel !== e) begin
                    n_bad++;
                    $display("FAIL %s collision new addr %0d: got %03h required %03h", name, i, rgb_pixel, e);
                end
            end
            n_cmp++;
            if (frame_err !== exp_err) begin
                n_bad++;
                $display("FAIL %s frame_err pixel %0d: got %0b required %0b", name, i, frame_err, exp_err);
            end
            n_cmp++;
            if (i == N - 1) begin
                if (load_done !== 1'b1 || rx_ready !== 1'b0 || load_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s done cycle: done/ready/busy=%0b%0b%0b required 100", name, load_done, rx_ready, load_busy);
                end
            end else if (load_done !== 1'b0 || load_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s mid-frame pixel %0d: done/busy=%0b%0b required 01", name, i, load_done, load_busy);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (load_done !== 1'b0 || rx_ready !== 1'b1 || load_busy !== 1'b0 || frame_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s after done: done/ready/busy/err=%0b%0b%0b%0b required 010%0b",
                     name, load_done, rx_ready, load_busy, frame_err, exp_err);
        end
        $display("%s: frame of %0d pixels loaded, frame_err=%0b", name, N, frame_err);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_ready !== 1'b1 || load_busy !== 1'b0 || load_done !== 1'b0 ||
            frame_err !== 1'b0 || rgb_pixel !== 12'h000) begin
            n_bad++;
            $display("FAIL reset values: ready/busy/done/err=%0b%0b%0b%0b rgb=%03h required 1000 000",
                     rx_ready, load_busy, load_done, frame_err, rgb_pixel);
        end
        rst = 1'b1;
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_basic();
        fill_frame();
        frame_hi[0] = 8'h12; frame_lo[0] = 8'h03;
        frame_hi[1] = 8'h45; frame_lo[1] = 8'h06;
        frame_hi[2] = SYNC;  // sync value inside a frame is plain data
        load_frame(0, -1, "test_basic");
        readback_all("test_basic");
    endtask

    task automatic test_ignore();
        send_byte(8'h00, 0);
        send_byte(8'h7F, 0);
        n_cmp++;
        if (load_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore non-sync: load_busy=%0b required 0", load_busy);
        end
        fill_frame();
        frame_hi[0] = 8'hFF; frame_lo[0] = 8'h0F;
        load_frame(0, -1, "test_ignore");
        readback_all("test_ignore");
    endtask

    task automatic test_err();
        fill_frame();
        frame_lo[5] = 8'hF3;
        load_frame(0, -1, "test_err");
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err sticky in idle: frame_err=%0b required 1", frame_err);
        end
        readback_all("test_err");
    endtask

    task automatic test_gaps();
        fill_frame();
        load_frame(50, -1, "test_gaps");
        readback_all("test_gaps");
    endtask

    task automatic test_collision();
        fill_frame();
        load_frame(0, 7, "test_collision");
    endtask

    task automatic test_reset_mid();
        fill_frame();
        send_byte(SYNC, 0);
        for (int i = 0; i < 100; i++) begin
            send_byte(frame_hi[i], 0);
            send_byte(frame_lo[i], 0);
            exp_mem[i] = {frame_hi[i], frame_lo[i][3:0]};
        end
        pixel_addr = 15'd3;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rgb_pixel !== 12'h000 || load_done !== 1'b0 || load_busy !== 1'b0 || rx_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL mid reset cycle %0d: rgb=%03h done/busy/ready=%0b%0b%0b required 000 001",
                         k, rgb_pixel, load_done, load_busy, rx_ready);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        send_byte(8'h12, 0);
        n_cmp++;
        if (load_busy !== 1'b0 || load_done !== 1'b0) begin
            n_bad++;
            $display("FAIL resync needed: busy/done=%0b%0b required 00", load_busy, load_done);
        end
        readback_all("test_reset_mid_partial");
        fill_frame();
        load_frame(0, -1, "test_reset_mid");
        readback_all("test_reset_mid");
    endtask

    initial begin
        #1;
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_ignore();
        test_err();
        test_gaps();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
